uart_tx_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `uart_tx` transmitter among `N_REQ` byte sources. It accepts bytes through per-requester valid/ready handshakes and drives the transmitter's start strobe and data. It holds a grant across multi-byte messages delimited by `last`, and releases on `last` or on an idle-hold timeout. It sits between the command/response producers and `uart_tx`.

---
 rtl/uart_tx_arbiter_pkg.sv | 18 +
 rtl/uart_tx_arbiter_rr_pick.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 146 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 571 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding and
// the helper used to size index and counter fields from parameters.
package uart_tx_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEND  = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    // Width needed to hold values 0..n-1, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker. Searches ptr+1, ptr+2, ..., ptr (mod N_REQ)
// and reports the first asserted request as one-hot, as an index and as "any".
module uart_rr_pick
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int PTR_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [PTR_W-1:0] idx,
    output logic             any
);

    // Scan upward from the slot after ptr; the last-served requester comes last.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int off = 1; off <= N_REQ; off++) begin
            if (!any && req[(int'(ptr) + off) % N_REQ]) begin
                any = 1'b1;
                gnt[(int'(ptr) + off) % N_REQ] = 1'b1;
                idx = PTR_W'((int'(ptr) + off) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter/sequencer sharing one uart_tx among N_REQ byte sources.
// A grant is held across a multi-byte message until 'last' is sent or the
// owner stays idle for HOLD_CYCLES cycles between bytes.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NB_DATA     = 8,
    parameter int N_REQ       = 4,
    parameter int HOLD_CYCLES = 256
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic [N_REQ-1:0]         i_req_valid,
    input  logic [N_REQ*NB_DATA-1:0] i_req_data,
    input  logic [N_REQ-1:0]         i_req_last,
    output logic [N_REQ-1:0]         o_req_ready,
    output logic                     o_tx_start,
    output logic [NB_DATA-1:0]       o_tx_data,
    input  logic                     i_tx_done,
    output logic [N_REQ-1:0]         o_grant,
    output logic                     o_busy
);

    localparam int PTR_W = idx_width(N_REQ);
    localparam int CNT_W = idx_width(HOLD_CYCLES);

    // After reset the pointer sits on the highest requester so requester 0 wins first.
    localparam logic [PTR_W-1:0] PTR_RESET = PTR_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [N_REQ-1:0] OH_RESET  = N_REQ'(1);

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [N_REQ-1:0]   owner_oh_q, owner_oh_d;
    logic [NB_DATA-1:0] tx_byte_q, tx_byte_d;
    logic               last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [N_REQ-1:0]   pick_gnt;
    logic [PTR_W-1:0]   pick_idx;
    logic               pick_any;

    // Per-requester byte slices of the flat data bus.
    logic [NB_DATA-1:0] req_byte [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
        assign req_byte[gi] = i_req_data[gi*NB_DATA +: NB_DATA];
    end

    uart_rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req (i_req_valid),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // State, pointer, owner, captured byte and hold counter registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            ptr_q      <= PTR_RESET;
            owner_q    <= '0;
            owner_oh_q <= OH_RESET;
            tx_byte_q  <= '0;
            last_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            owner_oh_q <= owner_oh_d;
            tx_byte_q  <= tx_byte_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
        end
    end

    // Next-state logic: arbitrate, accept a byte, strobe the transmitter, wait, hold.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        owner_oh_d = owner_oh_q;
        tx_byte_d  = tx_byte_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    owner_d    = pick_idx;
                    owner_oh_d = pick_gnt;
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                // Ready is high this cycle and the owner's valid is known high.
                tx_byte_d = req_byte[owner_q];
                last_d    = i_req_last[owner_q];
                state_d   = ST_START;
            end
            ST_START: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_tx_done) begin
                    if (last_q) begin
                        ptr_d   = owner_q;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d   = '0;
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                // Only the owner can continue; everyone else waits for release.
                if (i_req_valid[owner_q]) begin
                    state_d = ST_SEND;
                end else if (cnt_q == CNT_LAST) begin
                    ptr_d   = owner_q;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decode straight from registers so reset clears them without a clock.
    always_comb begin
        o_busy      = (state_q != ST_IDLE);
        o_grant     = o_busy ? owner_oh_q : '0;
        o_req_ready = (state_q == ST_SEND) ? owner_oh_q : '0;
        o_tx_start  = (state_q == ST_START);
        o_tx_data   = tx_byte_q;
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: queued byte sources, a uart_tx
// responder with random latency and a message-level round-robin model.
module tb_uart_tx_arbiter;

    localparam int NB   = 8;
    localparam int N    = 4;
    localparam int HOLD = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_last  = '0;
    logic [N*NB-1:0] req_data  = '0;
    logic [N-1:0]    ready, grant;
    logic            tx_start, busy, tx_done;
    logic [NB-1:0]   tx_data;
    logic            auto_done = 1'b0;
    logic            man_done  = 1'b0;
    bit              tx_auto   = 1'b1;

    int checks = 0;
    int errors = 0;

    // Source queues ({last, data}); the source process owns the read index.
    logic [8:0] src_q [N][$];
    int         src_rd [N];
    // Model: pending bytes per requester and expected transmit order.
    logic [8:0] mq [N][$];
    int         mdl_ptr = N - 1;
    int         exp_req[$];
    logic [7:0] exp_data[$];
    // Observed transmissions.
    int         obs_req[$];
    logic [7:0] obs_data[$];

    assign tx_done = auto_done | man_done;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NB_DATA     (NB),
        .N_REQ       (N),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_req_valid (req_valid),
        .i_req_data  (req_data),
        .i_req_last  (req_last),
        .o_req_ready (ready),
        .o_tx_start  (tx_start),
        .o_tx_data   (tx_data),
        .i_tx_done   (tx_done),
        .o_grant     (grant),
        .o_busy      (busy)
    );

    function automatic int oh2idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic bit drained();
        for (int k = 0; k < N; k++) if (src_rd[k] < src_q[k].size()) return 1'b0;
        return 1'b1;
    endfunction

    // Byte sources: hold valid/data/last until accepted, then present the next byte.
    initial begin
        bit         acc [N];
        logic [8:0] b;
        for (int k = 0; k < N; k++) src_rd[k] = 0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < N; k++) acc[k] = ready[k] && req_valid[k];
            @(posedge clk);
            #1;
            for (int k = 0; k < N; k++) begin
                if (rst) begin
                    src_rd[k] = src_q[k].size();
                    req_valid[k] = 1'b0;
                end else begin
                    if (acc[k]) begin
                        src_rd[k]++;
                        req_valid[k] = 1'b0;
                    end
                    if (!req_valid[k] && src_rd[k] < src_q[k].size()) begin
                        b = src_q[k][src_rd[k]];
                        req_valid[k] = 1'b1;
                        req_last[k]  = b[8];
                        req_data[k*NB +: NB] = b[7:0];
                    end
                end
            end
        end
    end

    // uart_tx stand-in: answers each start with a done pulse 1..4 cycles later.
    initial begin
        int d;
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1 && tx_auto) begin
                d = $urandom_range(1, 4);
                repeat (d) @(posedge clk);
                #1 auto_done = 1'b1;
                @(posedge clk);
                #1 auto_done = 1'b0;
            end
        end
    end

    // Transaction monitor: one line per byte handed to the transmitter.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1) begin
                obs_req.push_back(oh2idx(grant));
                obs_data.push_back(tx_data);
                $display("%0t tx req=%0d data=0x%02h", $time, oh2idx(grant), tx_data);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish by time limit, want finish");
        $fatal(1, "watchdog");
    end

    task automatic push_byte(input int k, input logic [7:0] d, input logic last);
        src_q[k].push_back({last, d});
        mq[k].push_back({last, d});
    endtask

    // Message-level round robin: the next requester after the last served one
    // with pending bytes sends its whole message (up to last, or until it runs dry).
    task automatic model_run();
        int         k;
        bit         found;
        logic [8:0] b;
        do begin
            found = 1'b0;
            for (int off = 1; off <= N && !found; off++) begin
                k = (mdl_ptr + off) % N;
                if (mq[k].size() > 0) found = 1'b1;
            end
            if (found) begin
                do begin
                    b = mq[k].pop_front();
                    exp_req.push_back(k);
                    exp_data.push_back(b[7:0]);
                end while (!b[8] && mq[k].size() > 0);
                mdl_ptr = k;
            end
        end while (found);
    endtask

    task automatic wait_quiet(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (!busy && req_valid == '0 && drained()) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (tx_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, grant, ready, tx_start, tx_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b grant=%b ready=%b start=%b data=%h want all 0",
                     busy, grant, ready, tx_start, tx_data);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, grant, ready, tx_start} !== '0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b grant=%b ready=%b start=%b want all 0",
                     busy, grant, ready, tx_start);
        end
        mdl_ptr = N - 1;
    endtask

    task automatic test_single_byte();
        bit ok;
        int ob = obs_req.size();
        int eb = exp_req.size();
        push_byte(0, 8'hA5, 1'b1);
        model_run();
        @(negedge clk);
        checks++;
        if (ready !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_c0: got ready=%b busy=%b want 0000 0", ready, busy);
        end
        @(negedge clk);
        checks++;
        if (ready !== 4'b0001 || grant !== 4'b0001 || tx_start !== 1'b0) begin
            errors++;
            $display("FAIL single_c1: got ready=%b grant=%b start=%b want 0001 0001 0", ready, grant, tx_start);
        end
        @(negedge clk);
        checks++;
        if (tx_start !== 1'b1 || tx_data !== 8'hA5 || ready !== 4'b0000) begin
            errors++;
            $display("FAIL single_c2: got start=%b data=%h ready=%b want 1 a5 0000", tx_start, tx_data, ready);
        end
        wait_quiet(ok);
        checks++;
        if (!ok || grant !== 4'b0000) begin
            errors++;
            $display("FAIL single_release: got idle=%0d grant=%b want 1 0000", ok, grant);
        end
        checks++;
        if (obs_req.size() - ob != exp_req.size() - eb) begin
            errors++;
            $display("FAIL single_count: got %0d bytes want %0d", obs_req.size() - ob, exp_req.size() - eb);
        end
    endtask

    task automatic test_rr_pair();
        bit ok;
        int ob = obs_req.size();
        int eb = exp_req.size();
        for (int m = 0; m < 2; m++) begin
            push_byte(1, 8'($urandom), 1'b1);
            push_byte(3, 8'($urandom), 1'b1);
        end
        model_run();
        wait_quiet(ok);
        checks++;
        if (!ok || obs_req.size() - ob != exp_req.size() - eb) begin
            errors++;
            $display("FAIL rr_count: got idle=%0d bytes=%0d want 1 %0d", ok, obs_req.size() - ob, exp_req.size() - eb);
        end
        for (int i = 0; i < exp_req.size() - eb && ob + i < obs_req.size(); i++) begin
            checks++;
            if (obs_req[ob+i] != exp_req[eb+i] || obs_data[ob+i] !== exp_data[eb+i]) begin
                errors++;
                $display("FAIL rr_order[%0d]: got req %0d data 0x%02h want req %0d data 0x%02h",
                         i, obs_req[ob+i], obs_data[ob+i], exp_req[eb+i], exp_data[eb+i]);
            end
        end
    endtask

    task automatic test_multibyte();
        bit ok;
        int n;
        int ob = obs_req.size();
        int eb = exp_req.size();
        push_byte(2, 8'h01, 1'b0);
        push_byte(2, 8'h02, 1'b0);
        push_byte(2, 8'h03, 1'b1);
        model_run();
        n = 0;
        while (grant !== 4'b0100 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (grant !== 4'b0100) begin
            errors++;
            $display("FAIL mb_grant: got %b want 0100", grant);
        end
        push_byte(0, 8'($urandom), 1'b1);
        model_run();
        wait_done(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL mb_done_wait: got no done want done");
        end
        @(negedge clk);
        checks++;
        if (ready !== 4'b0000 || grant !== 4'b0100) begin
            errors++;
            $display("FAIL mb_hold_cycle: got ready=%b grant=%b want 0000 0100", ready, grant);
        end
        @(negedge clk);
        checks++;
        if (ready !== 4'b0100) begin
            errors++;
            $display("FAIL mb_continue_ready: got %b want 0100", ready);
        end
        wait_quiet(ok);
        checks++;
        if (!ok || obs_req.size() - ob != exp_req.size() - eb) begin
            errors++;
            $display("FAIL mb_count: got idle=%0d bytes=%0d want 1 %0d", ok, obs_req.size() - ob, exp_req.size() - eb);
        end
        for (int i = 0; i < exp_req.size() - eb && ob + i < obs_req.size(); i++) begin
            checks++;
            if (obs_req[ob+i] != exp_req[eb+i] || obs_data[ob+i] !== exp_data[eb+i]) begin
                errors++;
                $display("FAIL mb_order[%0d]: got req %0d data 0x%02h want req %0d data 0x%02h",
                         i, obs_req[ob+i], obs_data[ob+i], exp_req[eb+i], exp_data[eb+i]);
            end
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int n;
        int stray = 0;
        int ob = obs_req.size();
        int eb = exp_req.size();
        push_byte(2, 8'h10, 1'b0);
        model_run();
        n = 0;
        while (grant !== 4'b0100 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (grant !== 4'b0100) begin
            errors++;
            $display("FAIL to_grant: got %b want 0100", grant);
        end
        push_byte(1, 8'($urandom), 1'b1);
        model_run();
        wait_done(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL to_done_wait: got no done want done");
        end
        for (int c = 1; c < HOLD; c++) begin
            @(negedge clk);
            if (ready !== 4'b0000) stray++;
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || grant !== 4'b0100) begin
            errors++;
            $display("FAIL to_last_hold: got busy=%b grant=%b want 1 0100", busy, grant);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || grant !== 4'b0000) begin
            errors++;
            $display("FAIL to_release: got busy=%b grant=%b want 0 0000", busy, grant);
        end
        @(negedge clk);
        checks++;
        if (ready !== 4'b0010) begin
            errors++;
            $display("FAIL to_next_ready: got %b want 0010", ready);
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL to_stray_ready: got %0d ready cycles in hold want 0", stray);
        end
        wait_quiet(ok);
        checks++;
        if (!ok || obs_req.size() - ob != exp_req.size() - eb) begin
            errors++;
            $display("FAIL to_count: got idle=%0d bytes=%0d want 1 %0d", ok, obs_req.size() - ob, exp_req.size() - eb);
        end
        for (int i = 0; i < exp_req.size() - eb && ob + i < obs_req.size(); i++) begin
            checks++;
            if (obs_req[ob+i] != exp_req[eb+i] || obs_data[ob+i] !== exp_data[eb+i]) begin
                errors++;
                $display("FAIL to_order[%0d]: got req %0d data 0x%02h want req %0d data 0x%02h",
                         i, obs_req[ob+i], obs_data[ob+i], exp_req[eb+i], exp_data[eb+i]);
            end
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        int n;
        int ob;
        int eb;
        // Reset while waiting for the transmitter.
        tx_auto = 1'b0;
        push_byte(0, 8'($urandom_range(1, 255)), 1'b1);
        n = 0;
        while (tx_start !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || tx_data === 8'h00) begin
            errors++;
            $display("FAIL ar_wait_reached: got busy=%b data=%h want 1 nonzero", busy, tx_data);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, grant, ready, tx_start, tx_data} !== '0) begin
            errors++;
            $display("FAIL ar_wait_outputs: got busy=%b grant=%b ready=%b start=%b data=%h want all 0",
                     busy, grant, ready, tx_start, tx_data);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < N; k++) mq[k].delete();
        mdl_ptr = N - 1;
        // Reset while the ready strobe is up.
        push_byte(1, 8'($urandom), 1'b1);
        n = 0;
        while (ready === 4'b0000 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (ready !== 4'b0010) begin
            errors++;
            $display("FAIL ar_send_reached: got ready=%b want 0010", ready);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, grant, ready, tx_start} !== '0) begin
            errors++;
            $display("FAIL ar_send_outputs: got busy=%b grant=%b ready=%b start=%b want all 0",
                     busy, grant, ready, tx_start);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < N; k++) mq[k].delete();
        mdl_ptr = N - 1;
        tx_auto = 1'b1;
        // Requester 0 must win first after reset.
        ob = obs_req.size();
        eb = exp_req.size();
        push_byte(3, 8'($urandom), 1'b1);
        push_byte(0, 8'($urandom), 1'b1);
        model_run();
        wait_quiet(ok);
        checks++;
        if (!ok || obs_req.size() - ob != exp_req.size() - eb) begin
            errors++;
            $display("FAIL ar_count: got idle=%0d bytes=%0d want 1 %0d", ok, obs_req.size() - ob, exp_req.size() - eb);
        end
        for (int i = 0; i < exp_req.size() - eb && ob + i < obs_req.size(); i++) begin
            checks++;
            if (obs_req[ob+i] != exp_req[eb+i] || obs_data[ob+i] !== exp_data[eb+i]) begin
                errors++;
                $display("FAIL ar_order[%0d]: got req %0d data 0x%02h want req %0d data 0x%02h",
                         i, obs_req[ob+i], obs_data[ob+i], exp_req[eb+i], exp_data[eb+i]);
            end
        end
    endtask

    task automatic test_spurious_done();
        bit ok;
        int ob;
        int eb;
        wait_quiet(ok);
        ob = obs_req.size();
        eb = exp_req.size();
        @(posedge clk);
        #1 man_done = 1'b1;
        @(posedge clk);
        #1 man_done = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || tx_start !== 1'b0) begin
                errors++;
                $display("FAIL sd_idle[%0d]: got busy=%b start=%b want 0 0", c, busy, tx_start);
            end
        end
        push_byte(2, 8'h21, 1'b0);
        wait_done(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL sd_done_wait: got no done want done");
        end
        @(posedge clk);
        #1 man_done = 1'b1;
        @(posedge clk);
        #1 man_done = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || grant !== 4'b0100 || tx_start !== 1'b0 || ready !== 4'b0000) begin
            errors++;
            $display("FAIL sd_hold: got busy=%b grant=%b start=%b ready=%b want 1 0100 0 0000",
                     busy, grant, tx_start, ready);
        end
        push_byte(2, 8'h22, 1'b1);
        model_run();
        wait_quiet(ok);
        checks++;
        if (!ok || obs_req.size() - ob != exp_req.size() - eb) begin
            errors++;
            $display("FAIL sd_count: got idle=%0d bytes=%0d want 1 %0d", ok, obs_req.size() - ob, exp_req.size() - eb);
        end
        for (int i = 0; i < exp_req.size() - eb && ob + i < obs_req.size(); i++) begin
            checks++;
            if (obs_req[ob+i] != exp_req[eb+i] || obs_data[ob+i] !== exp_data[eb+i]) begin
                errors++;
                $display("FAIL sd_order[%0d]: got req %0d data 0x%02h want req %0d data 0x%02h",
                         i, obs_req[ob+i], obs_data[ob+i], exp_req[eb+i], exp_data[eb+i]);
            end
        end
    endtask

    task automatic test_random();
        bit ok;
        int ob;
        int eb;
        int nmsg;
        int len;
        for (int r = 0; r < 4; r++) begin
            ob = obs_req.size();
            eb = exp_req.size();
            for (int k = 0; k < N; k++) begin
                nmsg = $urandom_range(0, 2);
                for (int m = 0; m < nmsg; m++) begin
                    len = $urandom_range(1, 3);
                    for (int b = 0; b < len; b++) push_byte(k, 8'($urandom), (b == len - 1));
                end
            end
            model_run();
            wait_quiet(ok);
            checks++;
            if (!ok || obs_req.size() - ob != exp_req.size() - eb) begin
                errors++;
                $display("FAIL rnd%0d_count: got idle=%0d bytes=%0d want 1 %0d",
                         r, ok, obs_req.size() - ob, exp_req.size() - eb);
            end
            for (int i = 0; i < exp_req.size() - eb && ob + i < obs_req.size(); i++) begin
                checks++;
                if (obs_req[ob+i] != exp_req[eb+i] || obs_data[ob+i] !== exp_data[eb+i]) begin
                    errors++;
                    $display("FAIL rnd%0d_order[%0d]: got req %0d data 0x%02h want req %0d data 0x%02h",
                             r, i, obs_req[ob+i], obs_data[ob+i], exp_req[eb+i], exp_data[eb+i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_rr_pair();
        test_multibyte();
        test_timeout();
        test_async_reset();
        test_spurious_done();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
